// File: rtl/keypad_pkg.sv
// Shared definitions for the hex keypad scanner: FSM encoding, matrix size,
// key map constant and small row-decode helpers.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  // Entry index is {row, col}; nibble 0 is row 0 / col 0.
  // r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E(*) 0 F(#) D
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] keymap_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] base;
    base = {row, col, 2'b00};
    return KEYMAP[base +: 4];
  endfunction

  // True when exactly one active-low row is asserted.
  function automatic logic row_is_single(input logic [3:0] rows);
    logic single;
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single = 1'b1;
      default:                            single = 1'b0;
    endcase
    return single;
  endfunction

  // Index of the single asserted row; only meaningful when row_is_single().
  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous active-low inputs; resets to the
// idle (all-ones) level so no spurious press is seen out of reset.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Capture the raw pins, then retime once more to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b1}};
      sync_r <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, samples the
// synchronized rows once per column slot, debounces press and release, and
// reports one hex code per accepted key.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 8,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_hex,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [3:0]       rs_s;
  logic [DIV_W-1:0] div_r;
  logic             sample_s;
  logic             row_single_s;
  logic             row_none_s;
  logic [1:0]       row_idx_s;

  state_t           state_r, state_s;
  logic [1:0]       col_idx_r, col_idx_s;
  logic [1:0]       cand_row_r, cand_row_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [CNT_W-1:0] rcnt_r, rcnt_s, rcnt_inc_s;
  logic             accept_s;

  logic [3:0]       col_n_r;
  logic [3:0]       key_hex_r;
  logic             key_valid_r;
  logic             key_held_r;

  keypad_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (rs_s)
  );

  assign sample_s     = (div_r == DIV_LAST);
  assign row_single_s = row_is_single(rs_s);
  assign row_none_s   = (rs_s == 4'b1111);
  assign row_idx_s    = row_index(rs_s);

  // Saturating increments so the debounce counters can never wrap.
  assign cnt_inc_s  = (cnt_r  >= CNT_MAX) ? CNT_MAX : cnt_r  + CNT_ONE;
  assign rcnt_inc_s = (rcnt_r >= CNT_MAX) ? CNT_MAX : rcnt_r + CNT_ONE;

  // Free-running column-slot divider; the last count of each slot is the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
    end else if (sample_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SCAN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, column rotation and debounce counting, evaluated at each sample.
  always_comb begin
    state_s    = state_r;
    col_idx_s  = col_idx_r;
    cand_row_s = cand_row_r;
    cnt_s      = cnt_r;
    rcnt_s     = rcnt_r;
    accept_s   = 1'b0;
    if (sample_s) begin
      case (state_r)
        SCAN: begin
          if (row_single_s) begin
            cand_row_s = row_idx_s;
            cnt_s      = CNT_ONE;
            if (CNT_ONE >= CNT_MAX) begin
              accept_s = 1'b1;
              rcnt_s   = CNT_ZERO;
              state_s  = HELD;
            end else begin
              state_s  = DEBOUNCE;
            end
          end else begin
            col_idx_s = col_idx_r + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_single_s && (row_idx_s == cand_row_r)) begin
            cnt_s = cnt_inc_s;
            if (cnt_inc_s >= CNT_MAX) begin
              accept_s = 1'b1;
              rcnt_s   = CNT_ZERO;
              state_s  = HELD;
            end else begin
              state_s  = DEBOUNCE;
            end
          end else begin
            cnt_s     = CNT_ZERO;
            state_s   = SCAN;
            col_idx_s = col_idx_r + 2'd1;
          end
        end
        HELD: begin
          // Column stays frozen; any other key activity just resets the release count.
          if (row_none_s) begin
            if (rcnt_inc_s >= CNT_MAX) begin
              rcnt_s  = CNT_ZERO;
              cnt_s   = CNT_ZERO;
              state_s = SCAN;
            end else begin
              rcnt_s  = rcnt_inc_s;
            end
          end else begin
            rcnt_s = CNT_ZERO;
          end
        end
        default: begin
          state_s = SCAN;
          cnt_s   = CNT_ZERO;
          rcnt_s  = CNT_ZERO;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Datapath registers: counters, candidate, column strobe and key outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx_r   <= 2'd0;
      cand_row_r  <= 2'd0;
      cnt_r       <= '0;
      rcnt_r      <= '0;
      col_n_r     <= 4'b1110;
      key_hex_r   <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      col_idx_r   <= col_idx_s;
      cand_row_r  <= cand_row_s;
      cnt_r       <= cnt_s;
      rcnt_r      <= rcnt_s;
      col_n_r     <= ~(4'b0001 << col_idx_s);
      key_valid_r <= accept_s;
      key_held_r  <= (state_s == HELD);
      if (accept_s) begin
        key_hex_r <= keymap_lookup(cand_row_s, col_idx_s);
      end else begin
        key_hex_r <= key_hex_r;
      end
    end
  end

  assign col_n     = col_n_r;
  assign key_hex   = key_hex_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench for hex_keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A keypad matrix model drives the rows from the column strobe; a
// cycle-level reference model predicts every output, and directed checks pin
// the key codes, pulse counts and reset behaviour.
module tb_hex_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_hex;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = 16'h0000;   // bit r*4+c = key at row r, column c held down

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  hex_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_hex   (key_hex),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      if (pressed[k] && !col_n[k % 4]) row_n[k / 4] = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  int keytab [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  logic [3:0] m_pipe1 = 4'hF, m_pipe2 = 4'hF;
  int m_phase = 0, m_col = 0, m_mode = 0, m_row = 0, m_agree = 0, m_quiet = 0;
  logic [3:0] m_hex = 4'h0;
  logic m_valid = 1'b0, m_held = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pipe1 = 4'hF; m_pipe2 = 4'hF; m_phase = 0; m_col = 0; m_mode = 0;
        m_row = 0; m_agree = 0; m_quiet = 0; m_hex = 4'h0; m_valid = 1'b0; m_held = 1'b0;
      end else begin
        logic [3:0] seen;
        int lows, which;
        seen = m_pipe2;
        m_pipe2 = m_pipe1;
        m_pipe1 = row_n;
        m_valid = 1'b0;
        if (m_phase == SD - 1) begin
          lows = 0; which = 0;
          for (int r = 0; r < 4; r++) if (!seen[r]) begin lows++; which = r; end
          if (m_mode == 2) begin
            m_quiet = (lows == 0) ? m_quiet + 1 : 0;
            if (m_quiet == DB) begin m_mode = 0; m_quiet = 0; m_held = 1'b0; end
          end else if (lows == 1 && (m_mode == 0 || which == m_row)) begin
            m_agree = (m_mode == 0) ? 1 : m_agree + 1;
            m_row = which;
            m_mode = 1;
            if (m_agree == DB) begin
              m_mode = 2; m_quiet = 0; m_held = 1'b1; m_valid = 1'b1;
              m_hex = 4'(keytab[m_row][m_col]);
            end
          end else begin
            m_mode = 0; m_agree = 0;
            m_col = (m_col + 1) % 4;
          end
        end
        m_phase = (m_phase + 1) % SD;
      end
    end
  end

  // Every-cycle comparison against the model, plus press-pulse counting.
  initial begin
    forever begin
      logic [3:0] exp_col;
      @(negedge clk);
      exp_col = ~(4'b0001 << m_col);
      tests++;
      if (col_n !== exp_col || key_hex !== m_hex || key_valid !== m_valid || key_held !== m_held) begin
        fails++;
        $display("FAIL cycle_model t=%0t: got col_n=%b hex=%h valid=%b held=%b, expected col_n=%b hex=%h valid=%b held=%b",
                 $time, col_n, key_hex, key_valid, key_held, exp_col, m_hex, m_valid, m_held);
      end
      if (key_valid === 1'b1) pulses++;
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [3:0] col_seq [5];
    int base;
    bit found;
    col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // 1: reset, idle scanning
    cycles(3);
    check("reset_col_n", col_n, 4'b1110);
    check("reset_key_hex", key_hex, 4'h0);
    check("reset_valid", {3'b000, key_valid}, 4'h0);
    check("reset_held", {3'b000, key_held}, 4'h0);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (col_n == 4'b1101) found = 1'b1;
    end
    check("idle_reach_col1", {3'b000, found}, 4'h1);
    for (int k = 2; k < 5; k++) begin
      cycles(SD);
      check("idle_col_rotation", col_n, col_seq[k]);
    end
    cycles(SD);
    check("idle_col_rotation", col_n, col_seq[1]);
    check("idle_no_pulse", 4'(pulses), 4'h0);
    check("idle_held", {3'b000, key_held}, 4'h0);

    // 2: press '6' (row 1, col 2)
    base = pulses;
    pressed[6] = 1'b1;
    cycles(60);
    check("press6_pulses", 4'(pulses - base), 4'h1);
    check("press6_hex", key_hex, 4'h6);
    check("press6_held", {3'b000, key_held}, 4'h1);
    check("press6_col_frozen", col_n, 4'b1011);

    // 3: release '6'
    base = pulses;
    pressed[6] = 1'b0;
    cycles(40);
    check("release6_held", {3'b000, key_held}, 4'h0);
    check("release6_hex_kept", key_hex, 4'h6);
    check("release6_no_pulse", 4'(pulses - base), 4'h0);

    // 4: bouncy press of '5' (row 1, col 1)
    base = pulses;
    pressed[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycles(3);
      pressed[5] = ~pressed[5];
    end
    pressed[5] = 1'b1;
    cycles(60);
    check("bounce5_pulses", 4'(pulses - base), 4'h1);
    check("bounce5_hex", key_hex, 4'h5);
    pressed[5] = 1'b0;
    cycles(40);

    // 5: hold '1', add '9', release in turn, then fresh '9'
    base = pulses;
    pressed[0] = 1'b1;
    cycles(60);
    check("hold1_hex", key_hex, 4'h1);
    pressed[10] = 1'b1;
    cycles(40);
    check("add9_no_pulse", 4'(pulses - base), 4'h1);
    check("add9_hex", key_hex, 4'h1);
    pressed[10] = 1'b0;
    cycles(40);
    check("drop9_still_held", {3'b000, key_held}, 4'h1);
    pressed[0] = 1'b0;
    cycles(40);
    check("drop1_released", {3'b000, key_held}, 4'h0);
    pressed[10] = 1'b1;
    cycles(60);
    check("fresh9_hex", key_hex, 4'h9);
    check("fresh9_pulses", 4'(pulses - base), 4'h2);
    pressed[10] = 1'b0;
    cycles(40);

    // 6: reset in the middle of debouncing 'D' (row 3, col 3)
    pressed[15] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && col_n == 4'b0111; i++) @(negedge clk);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col_n == 4'b0111) found = 1'b1;
    end
    check("d_reach_col3", {3'b000, found}, 4'h1);
    cycles(6);
    base = pulses;
    rst_n = 1'b0;
    #1;
    check("midreset_col_n", col_n, 4'b1110);
    check("midreset_hex", key_hex, 4'h0);
    check("midreset_valid", {3'b000, key_valid}, 4'h0);
    check("midreset_held", {3'b000, key_held}, 4'h0);
    pressed[15] = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(40);
    check("postreset_no_pulse", 4'(pulses - base), 4'h0);
    check("postreset_held", {3'b000, key_held}, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
